// File: rtl/mem_access_pkg.sv
// Shared definitions for the load/store access stage.
//   - RV32I load/store funct3 encodings
//   - FSM state encoding
//   - byte-enable base masks
//   - helpers for request checks and store lane alignment
package mem_access_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } mau_state_e;

    // Stores have no unsigned variants, so funct3[2] set on a store is illegal.
    function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
        logic bad;
        bad = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (we && f3[2]);
        return bad;
    endfunction

    // size is funct3[1:0]: 00 byte, 01 half, 10 word
    function automatic logic f3_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic mis;
        case (size)
            2'b01:   mis = off[0];
            2'b10:   mis = (off != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

    function automatic logic [3:0] store_mask(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] mask;
        case (size)
            2'b00:   mask = BE_BYTE << off;
            2'b01:   mask = BE_HALF << off;
            default: mask = BE_WORD;
        endcase
        return mask;
    endfunction

    // Replicating the low bytes puts the data on every lane; the mask picks the live ones.
    function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] wdata);
        logic [31:0] data;
        case (size)
            2'b00:   data = {4{wdata[7:0]}};
            2'b01:   data = {2{wdata[15:0]}};
            default: data = wdata;
        endcase
        return data;
    endfunction

endpackage

// File: rtl/mem_access_unit_load_extender.sv
// load_extender: selects the addressed byte/halfword of a cache word and
// sign- or zero-extends it according to the load funct3.
// Ports:
//   word    in  32  raw cache read word
//   offset  in  2   byte offset within the word
//   funct3  in  3   load funct3 (LB/LH/LW/LBU/LHU)
//   result  out 32  extended load value
module load_extender
    import mem_access_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[7:0];
        case (offset)
            2'd0: byte_sel = word[7:0];
            2'd1: byte_sel = word[15:8];
            2'd2: byte_sel = word[23:16];
            2'd3: byte_sel = word[31:24];
            default: byte_sel = word[7:0];
        endcase
        half_sel = offset[1] ? word[31:16] : word[15:0];
    end

    always_comb begin
        result = word;
        case (funct3)
            F3_B:    result = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   result = {24'h0, byte_sel};
            F3_H:    result = {{16{half_sel[15]}}, half_sel};
            F3_HU:   result = {16'h0, half_sel};
            default: result = word;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store access stage in front of the data cache.
// Checks each request, aligns store data/byte enables, waits out the cache
// read latency and extends load data; results leave over valid/ready.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   req_valid/req_ready             request handshake (ready only in IDLE)
//   req_we, req_funct3, req_addr,
//   req_wdata                       request fields
//   resp_valid/resp_ready           response handshake
//   resp_rdata                      extended load data (0 for stores/faults)
//   resp_misaligned/illegal/fault   error flags, only the highest priority set
//   dc_write_en, dc_addr,
//   dc_in_data                      registered cache write/address outputs
//   dc_out_data                     cache read data, RD_LAT cycles after dc_addr
//
// state | meaning
// IDLE  | ready for a request; errors go straight to RESP
// ISSUE | address on the cache; stores pulse dc_write_en this cycle
// WAIT  | load waiting out the cache read latency (down-counter)
// RESP  | response held until resp_ready
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter logic [31:0] MEM_LIMIT = 32'h0000_4000,
    parameter int          RD_LAT    = 1
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_misaligned,
    output logic        resp_illegal,
    output logic        resp_fault,
    output logic [3:0]  dc_write_en,
    output logic [29:0] dc_addr,
    output logic [31:0] dc_in_data,
    input  logic [31:0] dc_out_data
);

    localparam int             CNT_W    = (RD_LAT < 2) ? 1 : $clog2(RD_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_LAT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    mau_state_e       state_q, state_d;
    logic             err_illegal, err_misaligned, err_fault, any_err;
    logic             we_q;
    logic [1:0]       off_q;
    logic [2:0]       f3_q;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      ext_data;

    // Priority: illegal masks misaligned, which masks fault.
    always_comb begin
        err_illegal    = f3_illegal(req_we, req_funct3);
        err_misaligned = !err_illegal && f3_misaligned(req_funct3[1:0], req_addr[1:0]);
        err_fault      = !err_illegal && !err_misaligned && (req_addr >= MEM_LIMIT);
        any_err        = err_illegal || err_misaligned || err_fault;
    end

    load_extender u_load_extender (
        .word   (dc_out_data),
        .offset (off_q),
        .funct3 (f3_q),
        .result (ext_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid) state_d = any_err ? RESP : ISSUE;
            ISSUE:   state_d = we_q ? RESP : WAIT;
            WAIT:    if (cnt_q == CNT_ONE) state_d = RESP;
            RESP:    if (resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (state_q == IDLE);
        resp_valid = (state_q == RESP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dc_write_en     <= '0;
            dc_addr         <= '0;
            dc_in_data      <= '0;
            resp_rdata      <= '0;
            resp_misaligned <= 1'b0;
            resp_illegal    <= 1'b0;
            resp_fault      <= 1'b0;
            we_q            <= 1'b0;
            off_q           <= '0;
            f3_q            <= '0;
            cnt_q           <= '0;
        end else begin
            // Write enable is a single-cycle pulse unless re-armed on accept.
            dc_write_en <= '0;
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        resp_rdata      <= '0;
                        resp_illegal    <= err_illegal;
                        resp_misaligned <= err_misaligned;
                        resp_fault      <= err_fault;
                        if (!any_err) begin
                            dc_addr <= req_addr[31:2];
                            off_q   <= req_addr[1:0];
                            f3_q    <= req_funct3;
                            we_q    <= req_we;
                            if (req_we) begin
                                dc_write_en <= store_mask(req_funct3[1:0], req_addr[1:0]);
                                dc_in_data  <= store_data(req_funct3[1:0], req_wdata);
                            end
                        end
                    end
                end
                ISSUE: begin
                    if (!we_q) cnt_q <= CNT_LOAD;
                end
                WAIT: begin
                    cnt_q <= cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) resp_rdata <= ext_data;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_rdata      <= '0;
                        resp_misaligned <= 1'b0;
                        resp_illegal    <= 1'b0;
                        resp_fault      <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
